axi_burst_addr_gen: RTL
=======================

// Module: axi_burst_addr_gen
// PURPOSE
// - Sequences one AXI burst command (AW or AR) into per-beat transfer addresses for the data channel.
// - Sits between an AXI slave's address-channel capture and its W/R data path; one instance per direction.
// - Checks the command for legality (burst type, WRAP length, size vs. bus, 4KB boundary).
// - An illegal command produces an error pulse and no beats.
// PARAMETERS
// - ADDR_W      32  address width (matches axi_addr_t)
// - DATA_BYTES  4   data bus width in bytes; power of 2, 1..128
// - ID_W        4   transaction ID width (matches axi_mid_t)
// PORTS
// - ACLK        in   1       single clock; all logic rising-edge
// - ARESETn     in   1       asynchronous, active-low reset
// - cmd_valid   in   1       command present
// - cmd_ready   out  1       command accepted when cmd_valid & cmd_ready
// - cmd_id      in   ID_W    AxID
// - cmd_addr    in   ADDR_W  AxADDR (may be unaligned)
// - cmd_len     in   8       AxLEN; beats = len+1
// - cmd_size    in   3       AxSIZE; bytes/beat = 1<<size
// - cmd_burst   in   2       AxBURST (FIXED/INCR/WRAP; 2'b11 reserved)
// - beat_valid  out  1       beat address valid
// - beat_ready  in   1       beat consumed when beat_valid & beat_ready
// - beat_id     out  ID_W    ID of current burst
// - beat_addr   out  ADDR_W  address of current beat
// - beat_idx    out  8       beat number, 0..len
// - beat_last   out  1       high on beat len
// - err_valid   out  1       one-cycle pulse: illegal command rejected
// - err_id      out  ID_W    ID of rejected command; held until next error
// BEHAVIOUR
// - Reset (async assert, sync release): state IDLE; beat_valid=0, err_valid=0.
//   - beat_addr, beat_idx, beat_id and err_id reset to 0; beat_last=0.
// - FSM states:
//   - IDLE: no beat outstanding.
//   - BURST: beat_valid=1.
// - cmd_ready = (state==IDLE) | (beat_valid & beat_ready & beat_last).
//   - Back-to-back bursts run with zero bubble.
// - Legal command accepted in cycle N: beat 0 valid in cycle N+1 with beat_addr=cmd_addr and beat_idx=0. State goes to BURST.
// - Illegal command accepted in cycle N: err_valid=1 in cycle N+1 and err_id=cmd_id. No beat is produced. State goes to IDLE.
// - A command is illegal if any of these hold:
//   - burst==2'b11;
//   - (1<<size) > DATA_BYTES;
//   - WRAP with len not in {1,3,7,15};
//   - WRAP with cmd_addr not aligned to 1<<size;
//   - INCR where aligned_start + (len+1)<<size crosses a 4KB boundary.
// - Beat outputs are registered; they stay stable while beat_valid & ~beat_ready.
// - On each beat handshake with ~beat_last: beat_idx+1, and beat_addr advances:
//   - FIXED: beat_addr unchanged (cmd_addr every beat).
//   - INCR: next = (addr & ~((1<<size)-1)) + (1<<size). The first beat realigns an unaligned start.
//   - WRAP: total=(len+1)<<size and lower=addr & ~(total-1). next=aligned+(1<<size); if next==lower+total, then next=lower.
// - Address arithmetic is ADDR_W-bit modulo. The 4KB check prevents INCR overflow of the 4KB page.
// - beat_last = (beat_idx==len_reg); len_reg is captured at accept.
// - Handshake on the last beat returns to IDLE, unless a new command is accepted in the same cycle; then BURST reloads.
// - Reset mid-burst: the remaining beats are dropped; no error is raised.
// STRUCTURE
// - axi_defination_pkg gains:
//   - typedef enum {AG_IDLE, AG_BURST} addr_gen_state_e;
//   - localparam AXI_4KB_BOUNDARY = 4096;
//   - function axi_next_beat_addr(addr, size, len, burst) returning axi_addr_t.
// - Existing axi_addr_t, axi_length_t, axi_size_e and axi_burst_e are used for the command fields.
// - One sub-module, axi_cmd_legality_chk: combinational and stateless.
//   - Inputs: cmd fields. Outputs: illegal flag.
// TESTING
// - INCR addr=0x1002 len=3 size=2 -> beats 0x1002,0x1004,0x1008,0x100C; last on idx 3.
// - WRAP addr=0x34 len=3 size=2 -> 0x34,0x38,0x3C,0x30; FIXED addr=0x100 len=2 -> 0x100 x3.
// - Illegal commands -> err_valid 1 cycle with err_id; beat_valid stays 0:
//   - WRAP len=2;
//   - size=3 (DATA_BYTES=4);
//   - INCR addr=0xFF8 len=3 size=2;
//   - burst=2'b11.
// - Backpressure: beat_ready low 5 cycles mid-burst -> all beat outputs stable.
//   - Then back-to-back command on the last handshake -> next beat 0 in the following cycle.
// - ARESETn low at beat 2 of a len=7 INCR -> beat_valid=0 immediately.
//   - After release, cmd_ready=1 and a new burst starts at idx 0.

Source files
------------

// File: rtl/axi_burst_addr_gen_pkg.sv
// Shared AXI command types and helpers for the burst address generator.
//   axi_addr_t / axi_length_t / axi_size_e / axi_burst_e : command field types
//   addr_gen_state_e                                      : generator FSM states
//   axi_next_beat_addr()                                  : address of the following beat
package axi_burst_addr_gen_pkg;

  localparam int unsigned AXI_ADDR_W       = 32;
  localparam int unsigned AXI_ID_W         = 4;
  localparam int unsigned AXI_4KB_BOUNDARY = 4096;

  typedef logic [AXI_ADDR_W-1:0] axi_addr_t;
  typedef logic [AXI_ID_W-1:0]   axi_mid_t;
  typedef logic [7:0]            axi_length_t;

  typedef enum logic [2:0] {
    AXI_SIZE_1B   = 3'd0,
    AXI_SIZE_2B   = 3'd1,
    AXI_SIZE_4B   = 3'd2,
    AXI_SIZE_8B   = 3'd3,
    AXI_SIZE_16B  = 3'd4,
    AXI_SIZE_32B  = 3'd5,
    AXI_SIZE_64B  = 3'd6,
    AXI_SIZE_128B = 3'd7
  } axi_size_e;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10,
    AXI_BURST_RSVD  = 2'b11
  } axi_burst_e;

  typedef enum logic {
    AG_IDLE  = 1'b0,
    AG_BURST = 1'b1
  } addr_gen_state_e;

  // INCR/WRAP step from the size-aligned address; WRAP folds back to the
  // bottom of its (len+1)<<size window when it steps past the top.
  function automatic axi_addr_t axi_next_beat_addr(input axi_addr_t   addr,
                                                   input axi_size_e   size,
                                                   input axi_length_t len,
                                                   input axi_burst_e  burst);
    axi_addr_t bytes, aligned, total, lower, nxt;
    bytes   = axi_addr_t'(1) << size;
    aligned = addr & ~(bytes - axi_addr_t'(1));
    total   = (axi_addr_t'(len) + axi_addr_t'(1)) << size;
    lower   = addr & ~(total - axi_addr_t'(1));
    nxt     = aligned + bytes;
    case (burst)
      AXI_BURST_INCR: axi_next_beat_addr = nxt;
      AXI_BURST_WRAP: axi_next_beat_addr = (nxt == lower + total) ? lower : nxt;
      default:        axi_next_beat_addr = addr;
    endcase
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen_if.sv
// Command / beat / error signal bundle of axi_burst_addr_gen.
//   slave  : generator side (accepts commands, produces beats and errors)
//   master : upstream/downstream side (drives commands, consumes beats)
interface axi_burst_addr_gen_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ID_W   = 4
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ID_W-1:0]   cmd_id;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_len;
  logic [2:0]        cmd_size;
  logic [1:0]        cmd_burst;
  logic              beat_valid;
  logic              beat_ready;
  logic [ID_W-1:0]   beat_id;
  logic [ADDR_W-1:0] beat_addr;
  logic [7:0]        beat_idx;
  logic              beat_last;
  logic              err_valid;
  logic [ID_W-1:0]   err_id;

  modport slave (
    input  cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
    output cmd_ready, beat_valid, beat_id, beat_addr, beat_idx, beat_last,
           err_valid, err_id
  );

  modport master (
    output cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
    input  cmd_ready, beat_valid, beat_id, beat_addr, beat_idx, beat_last,
           err_valid, err_id
  );
endinterface

// File: rtl/axi_burst_addr_gen_cmd_legality_chk.sv
// Combinational legality check of one AXI burst command.
//   cmd_page_off : low 12 address bits (offset inside the 4KB page)
//   cmd_len/size/burst : AxLEN / AxSIZE / AxBURST
//   illegal      : command must be rejected
module axi_cmd_legality_chk
  import axi_burst_addr_gen_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 4
) (
  input  logic [11:0] cmd_page_off,
  input  logic [7:0]  cmd_len,
  input  logic [2:0]  cmd_size,
  input  logic [1:0]  cmd_burst,
  output logic        illegal
);
  logic [8:0]  bytes;
  logic [11:0] off_aligned;
  logic [15:0] span;
  logic [16:0] end_off;
  logic        rsvd, too_wide, wrap_len_bad, wrap_unaligned, incr_cross;

  always_comb begin
    bytes       = 9'd1 << cmd_size;
    off_aligned = cmd_page_off & ~(12'(bytes) - 12'd1);
    span        = (16'(cmd_len) + 16'd1) << cmd_size;
    end_off     = 17'(off_aligned) + 17'(span);

    rsvd           = (cmd_burst == AXI_BURST_RSVD);
    too_wide       = (32'(bytes) > DATA_BYTES);
    wrap_len_bad   = !(cmd_len == 8'd1 || cmd_len == 8'd3 ||
                       cmd_len == 8'd7 || cmd_len == 8'd15);
    wrap_unaligned = ((cmd_page_off[6:0] & (bytes[6:0] - 7'd1)) != 7'd0);
    // Ending exactly on the page boundary is legal; only a spill past it is not.
    incr_cross     = (end_off > 17'(AXI_4KB_BOUNDARY));

    illegal = rsvd | too_wide |
              ((cmd_burst == AXI_BURST_WRAP) & (wrap_len_bad | wrap_unaligned)) |
              ((cmd_burst == AXI_BURST_INCR) & incr_cross);
  end
endmodule

// File: rtl/axi_burst_addr_gen.sv
// Expands one AXI AW/AR command into per-beat addresses for the data channel.
//   ACLK, ARESETn : clock, asynchronous active-low reset
//   bus (slave)   : cmd_* command handshake, beat_* per-beat address stream,
//                   err_* one-cycle rejection pulse for illegal commands
module axi_burst_addr_gen
  import axi_burst_addr_gen_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_BYTES = 4,
  parameter int unsigned ID_W       = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  axi_burst_addr_gen_if.slave   bus
);
  addr_gen_state_e   state_q, state_d;
  logic [ADDR_W-1:0] beat_addr_q, beat_addr_d;
  logic [7:0]        beat_idx_q, beat_idx_d;
  logic [ID_W-1:0]   beat_id_q, beat_id_d;
  logic [ID_W-1:0]   err_id_q, err_id_d;
  logic              err_valid_q, err_valid_d;
  axi_length_t       len_q, len_d;
  axi_size_e         size_q, size_d;
  axi_burst_e        burst_q, burst_d;

  logic              illegal, beat_valid, beat_last, beat_hs, cmd_ready, accept;
  logic [ADDR_W-1:0] next_addr;

  axi_cmd_legality_chk #(
    .DATA_BYTES (DATA_BYTES)
  ) u_legality (
    .cmd_page_off (bus.cmd_addr[11:0]),
    .cmd_len      (bus.cmd_len),
    .cmd_size     (bus.cmd_size),
    .cmd_burst    (bus.cmd_burst),
    .illegal      (illegal)
  );

  assign beat_valid = (state_q == AG_BURST);
  assign beat_last  = beat_valid & (beat_idx_q == len_q);
  assign beat_hs    = beat_valid & bus.beat_ready;
  // Ready on the last handshake lets the next burst follow with no bubble.
  assign cmd_ready  = (state_q == AG_IDLE) | (beat_hs & beat_last);
  assign accept     = bus.cmd_valid & cmd_ready;
  assign next_addr  = ADDR_W'(axi_next_beat_addr(axi_addr_t'(beat_addr_q),
                                                 size_q, len_q, burst_q));

  always_comb begin
    state_d     = state_q;
    beat_addr_d = beat_addr_q;
    beat_idx_d  = beat_idx_q;
    beat_id_d   = beat_id_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    err_valid_d = 1'b0;
    err_id_d    = err_id_q;
    if (accept) begin
      if (illegal) begin
        state_d     = AG_IDLE;
        err_valid_d = 1'b1;
        err_id_d    = bus.cmd_id;
      end else begin
        state_d     = AG_BURST;
        beat_addr_d = bus.cmd_addr;
        beat_idx_d  = 8'd0;
        beat_id_d   = bus.cmd_id;
        len_d       = bus.cmd_len;
        size_d      = axi_size_e'(bus.cmd_size);
        burst_d     = axi_burst_e'(bus.cmd_burst);
      end
    end else if (beat_hs) begin
      if (beat_last) begin
        state_d = AG_IDLE;
      end else begin
        beat_idx_d  = beat_idx_q + 8'd1;
        beat_addr_d = next_addr;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= AG_IDLE;
      beat_addr_q <= '0;
      beat_idx_q  <= '0;
      beat_id_q   <= '0;
      len_q       <= '0;
      size_q      <= AXI_SIZE_1B;
      burst_q     <= AXI_BURST_FIXED;
      err_valid_q <= 1'b0;
      err_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      beat_addr_q <= beat_addr_d;
      beat_idx_q  <= beat_idx_d;
      beat_id_q   <= beat_id_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      err_valid_q <= err_valid_d;
      err_id_q    <= err_id_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready;
  assign bus.beat_valid = beat_valid;
  assign bus.beat_id    = beat_id_q;
  assign bus.beat_addr  = beat_addr_q;
  assign bus.beat_idx   = beat_idx_q;
  assign bus.beat_last  = beat_last;
  assign bus.err_valid  = err_valid_q;
  assign bus.err_id     = err_id_q;
endmodule
